// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and default byte width.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [N_REQ-1:0] rot_s;
    logic [IDX_W-1:0] rot_idx_s;

    function automatic logic [IDX_W-1:0] wrap_idx(input int a);
        return IDX_W'(a % N_REQ);
    endfunction

    // Rotate, priority-encode from the bottom, and map the winner back to an absolute index.
    always_comb begin
        rot_s     = '0;
        rot_idx_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_s[i] = req[wrap_idx(i + int'(rr_ptr))];
        end
        // Scan downward so the lowest set bit is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            rot_idx_s = rot_s[i] ? IDX_W'(i) : rot_idx_s;
        end
        win_idx = wrap_idx(int'(rot_idx_s) + int'(rr_ptr));
        win     = (|req) ? (ONE_HOT0 << win_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources with round-robin fairness;
// the grant is held from capture until the transmitter reports the frame done.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    input  logic                    tx_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [IDX_W-1:0]  win_idx_r;
    logic [N_REQ-1:0]  win_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [IDX_W-1:0]  next_ptr_s;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_r),
        .win     (win_s),
        .win_idx (win_idx_s)
    );

    // Byte mux for the current winner and the pointer value that follows the granted index.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data_s = (win_idx_s == IDX_W'(i)) ? data_in[i*DATA_W +: DATA_W] : sel_data_s;
        end
        next_ptr_s = (win_idx_r == IDX_W'(N_REQ - 1)) ? '0 : win_idx_r + IDX_W'(1);
    end

    // Arbiter FSM with grant, byte and pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            win_idx_r <= '0;
            gnt       <= '0;
            tx_data   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        gnt       <= win_s;
                        tx_data   <= sel_data_s;
                        win_idx_r <= win_idx_s;
                        state_r   <= ST_LAUNCH;
                    end else begin
                        gnt       <= '0;
                    end
                end
                ST_LAUNCH: begin
                    if (!tx_busy) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_LAUNCH;
                    end
                end
                ST_WAIT: begin
                    // tx_done is honoured only here; pulses seen elsewhere are stale.
                    if (tx_done) begin
                        gnt      <= '0;
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_WAIT;
                    end
                end
                default: begin
                    gnt     <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start = (state_r == ST_LAUNCH) && !tx_busy;
    assign ack      = ((state_r == ST_WAIT) && tx_done) ? gnt : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with hand-computed expectations.
module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;

    int pass_cnt;
    int total_cnt;

    logic [7:0] exp_byte [4];

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 || ack !== 4'b0000)
                $display("FAIL reset_outputs cyc%0d: gnt=%b start=%b data=%h ack=%b, want 0/0/00/0",
                         i, gnt, tx_start, tx_data, ack);
            else pass_cnt++;
        end
        reset = 1'b0;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001 || tx_data !== 8'h11 || tx_start !== 1'b1)
            $display("FAIL reset_first_grant: gnt=%b data=%h start=%b, want 0001/11/1", gnt, tx_data, tx_start);
        else pass_cnt++;
        tick();
        tx_done = 1'b1;
        #1;
        total_cnt++;
        if (ack !== 4'b0001)
            $display("FAIL reset_first_ack: ack=%b, want 0001", ack);
        else pass_cnt++;
        tick();
        tx_done = 1'b0;
        req     = 4'b0000;
        tick();
        total_cnt++;
        if (gnt !== 4'b0000)
            $display("FAIL reset_idle_no_req: gnt=%b, want 0000", gnt);
        else pass_cnt++;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        total_cnt++;
        if (gnt !== 4'b0100 || tx_data !== 8'hA5 || tx_start !== 1'b1)
            $display("FAIL single_grant: gnt=%b data=%h start=%b, want 0100/a5/1", gnt, tx_data, tx_start);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (tx_start !== 1'b0 || gnt !== 4'b0100)
            $display("FAIL single_start_once: start=%b gnt=%b, want 0/0100", tx_start, gnt);
        else pass_cnt++;
        for (int i = 0; i < 9; i++) tick();
        total_cnt++;
        if (ack !== 4'b0000)
            $display("FAIL single_no_early_ack: ack=%b, want 0000", ack);
        else pass_cnt++;
        tx_done = 1'b1;
        #1;
        total_cnt++;
        if (ack !== 4'b0100)
            $display("FAIL single_ack: ack=%b, want 0100", ack);
        else pass_cnt++;
        tick();
        tx_done = 1'b0;
        req     = 4'b0000;
        #1;
        total_cnt++;
        if (ack !== 4'b0000 || gnt !== 4'b0000)
            $display("FAIL single_after_ack: ack=%b gnt=%b, want 0000/0000", ack, gnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_gnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            tick();
            total_cnt++;
            if (gnt !== exp_gnt || tx_data !== exp_byte[k % 4] || tx_start !== 1'b1)
                $display("FAIL rotation_grant%0d: gnt=%b data=%h start=%b, want %b/%h/1",
                         k, gnt, tx_data, tx_start, exp_gnt, exp_byte[k % 4]);
            else pass_cnt++;
            tick();
            tx_done = 1'b1;
            #1;
            total_cnt++;
            if (ack !== exp_gnt)
                $display("FAIL rotation_ack%0d: ack=%b, want %b", k, ack, exp_gnt);
            else pass_cnt++;
            tick();
            tx_done = 1'b0;
            #1;
            total_cnt++;
            if (gnt !== 4'b0000 || tx_start !== 1'b0)
                $display("FAIL rotation_gap%0d: gnt=%b start=%b, want 0000/0", k, gnt, tx_start);
            else pass_cnt++;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_busy();
        // pointer is 1 after the rotation ended on requester 0
        req     = 4'b0010;
        tx_busy = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) tx_done = 1'b1;
            else tx_done = 1'b0;
            #1;
            total_cnt++;
            if (gnt !== 4'b0010 || tx_data !== 8'h22 || tx_start !== 1'b0 || ack !== 4'b0000)
                $display("FAIL busy_hold%0d: gnt=%b data=%h start=%b ack=%b, want 0010/22/0/0000",
                         c, gnt, tx_data, tx_start, ack);
            else pass_cnt++;
            tick();
        end
        tx_done = 1'b0;
        tx_busy = 1'b0;
        #1;
        total_cnt++;
        if (tx_start !== 1'b1 || gnt !== 4'b0010)
            $display("FAIL busy_release_start: start=%b gnt=%b, want 1/0010", tx_start, gnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (tx_start !== 1'b0)
            $display("FAIL busy_single_pulse: start=%b, want 0", tx_start);
        else pass_cnt++;
        tx_done = 1'b1;
        #1;
        total_cnt++;
        if (ack !== 4'b0010)
            $display("FAIL busy_ack: ack=%b, want 0010", ack);
        else pass_cnt++;
        tick();
        tx_done = 1'b0;
        req     = 4'b0000;
        tick();
    endtask

    task automatic test_early_drop();
        // pointer is 2; requester 3 is the only one asking
        req = 4'b1000;
        tick();
        total_cnt++;
        if (gnt !== 4'b1000 || tx_data !== 8'h44)
            $display("FAIL drop_grant: gnt=%b data=%h, want 1000/44", gnt, tx_data);
        else pass_cnt++;
        tick();
        req = 4'b0000;
        tick();
        tick();
        total_cnt++;
        if (gnt !== 4'b1000 || tx_data !== 8'h44)
            $display("FAIL drop_hold: gnt=%b data=%h, want 1000/44", gnt, tx_data);
        else pass_cnt++;
        tx_done = 1'b1;
        #1;
        total_cnt++;
        if (ack !== 4'b1000)
            $display("FAIL drop_ack: ack=%b, want 1000", ack);
        else pass_cnt++;
        tick();
        tx_done = 1'b0;
        #1;
        total_cnt++;
        if (gnt !== 4'b0000)
            $display("FAIL drop_clear: gnt=%b, want 0000", gnt);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        // pointer 0: serve requester 1 fully, leaving the pointer at 2
        req = 4'b0010;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        req     = 4'b0100;
        tick();
        total_cnt++;
        if (gnt !== 4'b0100)
            $display("FAIL midrst_pre_grant: gnt=%b, want 0100", gnt);
        else pass_cnt++;
        tick();
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL midrst_cleared: gnt=%b start=%b data=%h, want 0000/0/00", gnt, tx_start, tx_data);
        else pass_cnt++;
        tx_done = 1'b1;
        #1;
        total_cnt++;
        if (ack !== 4'b0000)
            $display("FAIL midrst_stale_done: ack=%b, want 0000", ack);
        else pass_cnt++;
        tick();
        tx_done = 1'b0;
        req     = 4'b1111;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001 || tx_data !== 8'h11)
            $display("FAIL midrst_ptr_restart: gnt=%b data=%h, want 0001/11", gnt, tx_data);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        exp_byte[0] = 8'h11;
        exp_byte[1] = 8'h22;
        exp_byte[2] = 8'hA5;
        exp_byte[3] = 8'h44;
        data_in     = {exp_byte[3], exp_byte[2], exp_byte[1], exp_byte[0]};
        reset       = 1'b1;
        req         = 4'b0000;
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_early_drop();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
